// File: rtl/matmul_pkg.sv
// Shared types, default geometry and sizing helpers for the matmul operand-fetch sequencer.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fetch_state_t;

  localparam int DEF_ROWS    = 64;
  localparam int DEF_K       = 64;
  localparam int DEF_LANES   = 64;
  localparam int DEF_ROM_LAT = 1;

  function automatic int chunk_count(input int k, input int lanes);
    return k / lanes;
  endfunction

  // Counter/bus width that stays at least one bit for degenerate sizes.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_fetch_seq_if.sv
// Start/busy/done handshake plus ROM address and returned-chunk sideband of the fetch sequencer.
interface matmul_fetch_seq_if
  import matmul_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int K    = DEF_K
);
  logic                          start;
  logic                          busy;
  logic                          done;
  logic                          issue;
  logic [width_of(ROWS*K)-1:0]   addr_a;
  logic [width_of(K)-1:0]        addr_b;
  logic                          data_valid;
  logic                          first;
  logic                          last;
  logic [width_of(ROWS)-1:0]     row_idx;
  logic [15:0]                   cycles;

  modport master (
    input  start,
    output busy, done, issue, addr_a, addr_b, data_valid, first, last, row_idx, cycles
  );

  modport slave (
    output start,
    input  busy, done, issue, addr_a, addr_b, data_valid, first, last, row_idx, cycles
  );

endinterface

// File: rtl/matmul_fetch_seq_sideband_delay.sv
// DEPTH-stage shift register aligning the issue sideband with ROM read data.
module sideband_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: every stage is reset, because a reset mid-run must not leak in-flight beats as data_valid.
  // NOTE: non-blocking assignments let all stages shift together on one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/matmul_fetch_seq.sv
// Operand-fetch sequencer: walks A/B ROM chunk addresses, delays sideband by ROM_LAT.
// Optional run-cycle counter built only when FETCH_SEQ_PERF_EN is defined.
module matmul_fetch_seq
  import matmul_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int K       = DEF_K,
  parameter int LANES   = DEF_LANES,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input logic                clock,
  input logic                reset,
  matmul_fetch_seq_if.master bus
);

  localparam int CHUNKS = chunk_count(K, LANES);
  localparam int RW     = width_of(ROWS);
  localparam int CW     = width_of(CHUNKS);
  localparam int AW     = width_of(ROWS * K);
  localparam int BW     = width_of(K);
  localparam int SBW    = RW + 3;

  if (K % LANES != 0) begin : g_bad_lanes
    $error("matmul_fetch_seq: K must be a multiple of LANES");
  end
  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_lat
    $error("matmul_fetch_seq: ROM_LAT must be within 1..4");
  end

  fetch_state_t   state, state_nx;
  logic [RW-1:0]  row_q;
  logic [CW-1:0]  chunk_q;
  logic [2:0]     drain_q;
  logic           issue, busy, start_ok, last_chunk, last_row;
  logic [SBW-1:0] sb_in, sb_out;

  // NOTE: every output of this block is given a default first so no latch can be inferred.
  always_comb begin
    issue      = (state == ISSUE);
    busy       = (state == ISSUE) || (state == DRAIN);
    start_ok   = bus.start && ((state == IDLE) || (state == DONE));
    last_chunk = (chunk_q == CW'(CHUNKS - 1));
    last_row   = (row_q == RW'(ROWS - 1));
    state_nx   = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = ISSUE;
      ISSUE:   if (last_chunk && last_row) state_nx = DRAIN;
      DRAIN:   if (drain_q == 3'd1) state_nx = DONE;
      DONE:    state_nx = bus.start ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Row wraps to 0 after the final chunk so the sequencer idles at the base address.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_q   <= '0;
      chunk_q <= '0;
      drain_q <= '0;
    end else if (start_ok) begin
      row_q   <= '0;
      chunk_q <= '0;
    end else if (issue) begin
      if (last_chunk) begin
        chunk_q <= '0;
        row_q   <= last_row ? '0 : row_q + 1'b1;
      end else begin
        chunk_q <= chunk_q + 1'b1;
      end
      if (last_chunk && last_row) drain_q <= 3'(ROM_LAT);
    end else if (state == DRAIN) begin
      drain_q <= drain_q - 3'd1;
    end
  end

  assign bus.issue  = issue;
  assign bus.busy   = busy;
  assign bus.done   = (state == DONE);
  assign bus.addr_a = issue ? AW'(32'(row_q) * 32'(K) + 32'(chunk_q) * 32'(LANES)) : '0;
  assign bus.addr_b = issue ? BW'(32'(chunk_q) * 32'(LANES)) : '0;

  // Flags are gated by issue so idle cycles carry an all-zero bundle down the pipe.
  assign sb_in = {issue,
                  issue && (chunk_q == '0),
                  issue && last_chunk,
                  issue ? row_q : '0};

  sideband_delay #(
    .DEPTH(ROM_LAT),
    .WIDTH(SBW)
  ) u_sideband (
    .clock(clock),
    .reset(reset),
    .din  (sb_in),
    .dout (sb_out)
  );

  assign bus.data_valid = sb_out[SBW-1];
  assign bus.first      = sb_out[SBW-2];
  assign bus.last       = sb_out[SBW-3];
  assign bus.row_idx    = sb_out[RW-1:0];

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] cycles_q;

  always_ff @(posedge clock) begin
    if (reset)                               cycles_q <= '0;
    else if (start_ok)                       cycles_q <= '0;
    else if (busy && cycles_q != 16'hFFFF)   cycles_q <= cycles_q + 16'd1;
  end

  assign bus.cycles = cycles_q;
`else
  assign bus.cycles = '0;
`endif

endmodule

// File: tb/tb_matmul_fetch_seq.sv
// Randomized bench for matmul_fetch_seq: three geometries checked cycle-by-cycle against a timeline model.
module tb_matmul_fetch_seq;

  localparam int CR[3]   = '{64, 4, 64};
  localparam int CK[3]   = '{64, 8, 64};
  localparam int CL[3]   = '{64, 4, 64};
  localparam int CLAT[3] = '{1,  2, 4};

`ifdef FETCH_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        issue;
    logic [11:0] addr_a;
    logic [5:0]  addr_b;
    logic        data_valid;
    logic        first;
    logic        last;
    logic [5:0]  row_idx;
    logic [15:0] cycles;
  } obs_t;

  logic        clock = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  start_v = 3'b000;
  obs_t        obs [3];
  logic [15:0] last_cyc [3];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  matmul_fetch_seq_if #(.ROWS(CR[0]), .K(CK[0])) b0 ();
  matmul_fetch_seq_if #(.ROWS(CR[1]), .K(CK[1])) b1 ();
  matmul_fetch_seq_if #(.ROWS(CR[2]), .K(CK[2])) b2 ();

  matmul_fetch_seq #(.ROWS(CR[0]), .K(CK[0]), .LANES(CL[0]), .ROM_LAT(CLAT[0])) u0 (
    .clock(clock), .reset(rst_v[0]), .bus(b0.master));
  matmul_fetch_seq #(.ROWS(CR[1]), .K(CK[1]), .LANES(CL[1]), .ROM_LAT(CLAT[1])) u1 (
    .clock(clock), .reset(rst_v[1]), .bus(b1.master));
  matmul_fetch_seq #(.ROWS(CR[2]), .K(CK[2]), .LANES(CL[2]), .ROM_LAT(CLAT[2])) u2 (
    .clock(clock), .reset(rst_v[2]), .bus(b2.master));

  assign b0.start = start_v[0];
  assign b1.start = start_v[1];
  assign b2.start = start_v[2];

  assign obs[0] = '{busy: b0.busy, done: b0.done, issue: b0.issue, addr_a: 12'(b0.addr_a),
                    addr_b: 6'(b0.addr_b), data_valid: b0.data_valid, first: b0.first,
                    last: b0.last, row_idx: 6'(b0.row_idx), cycles: b0.cycles};
  assign obs[1] = '{busy: b1.busy, done: b1.done, issue: b1.issue, addr_a: 12'(b1.addr_a),
                    addr_b: 6'(b1.addr_b), data_valid: b1.data_valid, first: b1.first,
                    last: b1.last, row_idx: 6'(b1.row_idx), cycles: b1.cycles};
  assign obs[2] = '{busy: b2.busy, done: b2.done, issue: b2.issue, addr_a: 12'(b2.addr_a),
                    addr_b: 6'(b2.addr_b), data_valid: b2.data_valid, first: b2.first,
                    last: b2.last, row_idx: 6'(b2.row_idx), cycles: b2.cycles};

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs in cycle tt of a run (tt=1 is the first issue; tt<=0 is idle before it).
  function automatic obs_t expect_at(input int i, input int tt, input logic [15:0] prev);
    int   ch, n, lat, j;
    obs_t e;
    ch  = CK[i] / CL[i];
    n   = CR[i] * ch;
    lat = CLAT[i];
    e   = '0;
    if (tt <= 0) begin
      e.cycles = PERF ? prev : 16'd0;
      return e;
    end
    if (tt <= n) begin
      j        = tt - 1;
      e.issue  = 1'b1;
      e.addr_a = 12'((j / ch) * CK[i] + (j % ch) * CL[i]);
      e.addr_b = 6'((j % ch) * CL[i]);
    end
    if (tt > lat && tt <= n + lat) begin
      j            = tt - 1 - lat;
      e.data_valid = 1'b1;
      e.first      = (j % ch == 0);
      e.last       = (j % ch == ch - 1);
      e.row_idx    = 6'(j / ch);
    end
    e.busy = (tt <= n + lat);
    e.done = (tt == n + lat + 1);
    if (PERF) e.cycles = 16'((tt - 1 < n + lat) ? tt - 1 : n + lat);
    return e;
  endfunction

  // One run (or back-to-back runs with start held), optionally aborted by reset in cycle `abort`.
  task automatic run(input int i, input int runs, input bit hold, input int abort);
    int ch, n, p, gap, hold_len, tt;
    ch  = CK[i] / CL[i];
    n   = CR[i] * ch;
    p   = n + CLAT[i] + 1;
    gap = $urandom_range(0, 3);
    repeat (gap) begin
      @(negedge clock);
      check($sformatf("u%0d idle", i), obs[i], expect_at(i, 0, last_cyc[i]));
    end
    hold_len   = hold ? runs * p : $urandom_range(1, n + CLAT[i]);
    start_v[i] = 1'b1;
    for (int t = 1; t <= runs * p + 1; t++) begin
      @(negedge clock);
      tt = (t <= runs * p) ? ((t - 1) % p) + 1 : p + 1;
      check($sformatf("u%0d cyc%0d", i, t), obs[i], expect_at(i, tt, last_cyc[i]));
      if (t == hold_len) start_v[i] = 1'b0;
      if (abort != 0 && t == abort) begin
        start_v[i] = 1'b0;
        rst_v[i]   = 1'b1;
        @(negedge clock);
        check($sformatf("u%0d reset", i), obs[i], '0);
        rst_v[i] = 1'b0;
        repeat (p) begin
          @(negedge clock);
          check($sformatf("u%0d aborted", i), obs[i], '0);
        end
        last_cyc[i] = '0;
        return;
      end
    end
    last_cyc[i] = 16'(n + CLAT[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  i;
    bit  hold;
    for (int k = 0; k < 3; k++) last_cyc[k] = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 3; k++) check($sformatf("u%0d in reset", k), obs[k], '0);
    rst_v = 3'b000;
    @(negedge clock);
    for (int k = 0; k < 3; k++) check($sformatf("u%0d after reset", k), obs[k], '0);

    run(0, 1, 1'b0, 0);
    run(0, 1, 1'b0, 20);
    run(0, 1, 1'b0, 0);
    run(1, 1, 1'b0, 0);
    run(1, 2, 1'b1, 0);
    run(2, 1, 1'b0, 0);
    repeat (4) begin
      i    = $urandom_range(0, 2);
      hold = 1'($urandom_range(0, 1));
      run(i, hold ? 2 : 1, hold, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_fetch_seq.md
# matmul_fetch_seq

Operand-fetch sequencer for the matrix-vector multiply datapath. It drives the read addresses of the A-matrix and B-vector ROM banks one chunk per cycle. It also delays the issue strobe by the ROM read latency, so each returned chunk arrives with valid, first and last flags for the downstream multiplier/adder-tree accumulator. A start/busy/done handshake and a run-cycle counter feed the seven-segment display path.

## Interface
- ROWS, 64, result rows (one dot product per row)
- K, 64, dot-product length
- LANES, 64, operands per chunk; K % LANES == 0, CHUNKS = K/LANES
- ROM_LAT, 1, ROM read latency in cycles, legal range 1..4
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  run request; sampled only in IDLE or DONE
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse at run completion
- issue  out  1  addr_a/addr_b valid this cycle
- addr_a  out  $clog2(ROWS*K)  chunk base into A; lane l reads addr_a+l
- addr_b  out  $clog2(K)  chunk base into B; lane l reads addr_b+l
- data_valid  out  1  ROM data for an issued chunk present this cycle
- first  out  1  with data_valid: first chunk of a row (clear accumulator)
- last  out  1  with data_valid: last chunk of a row (row result complete)
- row_idx  out  $clog2(ROWS)  row of the chunk on data_valid
- cycles  out  16  run cycle count (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 → ISSUE. Row counter r, chunk counter c and cycles clear.
- ISSUE: issue=1 every cycle. addr_a = r*K + c*LANES, addr_b = c*LANES.
  - c increments; it wraps to 0 at CHUNKS-1 and r increments.
  - On the issue with r=ROWS-1 and c=CHUNKS-1 → DRAIN, drain counter = ROM_LAT.
- DRAIN: issue=0; the counter decrements each cycle; at 1 → DONE.
- DONE: done=1 for exactly one cycle → IDLE. start=1 in DONE → ISSUE directly; done still pulses.
- start during ISSUE/DRAIN is ignored; it is not queued.
- Sideband pipeline: {issue, c==0, c==CHUNKS-1, r} delays ROM_LAT stages to {data_valid, first, last, row_idx}.
- If CHUNKS=1, first and last are both high on every beat.
- Address arithmetic is unsigned. Widths are sized so neither address can overflow; no wrap is legal within a run.
- Reset: state IDLE. Every output 0, including the pipeline stages and cycles.
  - Reset mid-run aborts the run: no further data_valid and no done pulse.

## Timing
- start sampled at edge 0 → first issue in cycle 1.
- data_valid first asserts in cycle 1+ROM_LAT.
- Last issue in cycle ROWS*CHUNKS. Last data_valid in cycle ROWS*CHUNKS+ROM_LAT; done in the following cycle.
- busy covers cycles 1 .. ROWS*CHUNKS+ROM_LAT.
- No backpressure: the consumer must accept one chunk per cycle while data_valid is high.

## Configuration
- FETCH_SEQ_PERF_EN defined:
  - cycles increments on every cycle busy=1.
  - It saturates at 16'hFFFF, holds after done, and clears on start acceptance.
  - With defaults, cycles reads 65 after a run.
- FETCH_SEQ_PERF_EN undefined: no counter is built and cycles is tied to 0.

## Structure
- Package matmul_pkg holds:
  - the fetch_state_t enum (IDLE, ISSUE, DRAIN, DONE)
  - the default ROWS/K/LANES/ROM_LAT localparams
  - a function computing CHUNKS
- One sub-module, sideband_delay: a parameterised DEPTH×WIDTH shift register with synchronous reset. It carries the {valid, first, last, row} bundle.
- Elaboration-time assertions:
  - K % LANES == 0
  - 1 ≤ ROM_LAT ≤ 4

## Test plan
- Defaults, single start pulse:
  - issue cycles 1..64 with addr_a = 0, 64, …, 4032 and addr_b = 0.
  - data_valid cycles 2..65 with first=last=1 and row_idx 0..63.
  - done in cycle 66; cycles=65.
- ROWS=4, K=8, LANES=4, ROM_LAT=2:
  - addr_a sequence 0, 4, 8, 12, …, 28; addr_b alternates 0, 4.
  - first on even beats, last on odd beats.
  - done in cycle 11.
- start held high for a whole run: no restart during busy. A new run begins directly from DONE, with a single done pulse between runs.
- Reset asserted in cycle 20 of a default run: all outputs 0 in the next cycle, no done, and a following start runs cleanly from r=0.
- Without FETCH_SEQ_PERF_EN, cycles stays 0 for the whole run. With it, cycles=65 after the run and holds until the next start.
- ROM_LAT=4, defaults: data_valid in cycles 5..68, done in cycle 69, busy low in cycle 69.
